data_memory_ctrl: RTL
=====================

Name: data_memory_ctrl

Overview:
- Parametrised, byte-addressed data memory for the single-cycle/pipelined CPU datapath; successor to the word-only data memory.
- Supports byte, halfword and word loads/stores, with sign or zero extension on loads.
- Load data is returned through a registered one-cycle response. Misaligned and out-of-range accesses are detected.
- A hardware clear state machine zeroes the array after reset, so no simulation-only initial block is needed.

Parameters:
- DEPTH, 128, number of 32-bit words (power of 2, >= 2).
- ADDR_W, 32, width of the byte address input.
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset before accepting requests; 0 = skip clearing.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active low.
- req  in  1  access request; sampled only when ready=1.
- we  in  1  1 = store, 0 = load.
- addr  in  ADDR_W  byte address, little-endian.
- size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = reserved.
- unsigned_ld  in  1  1 = zero-extend loads, 0 = sign-extend loads.
- wdata  in  32  store data; byte/half taken from low bits.
- ready  out  1  block can accept a request this cycle.
- rdata  out  32  load result; valid when rvalid=1.
- rvalid  out  1  one-cycle pulse marking a load response.
- misalign  out  1  one-cycle pulse: the previous accepted access was misaligned or used size 3.
- out_of_range  out  1  one-cycle pulse: the previous accepted access had addr >= 4*DEPTH.

Behaviour:
- Clock/reset: one clock, clk. rst_n is asynchronous, active low.
- Reset values: ready=0, rdata=0, rvalid=0, misalign=0, out_of_range=0, clear counter=0.
- Reset state: CLEAR if CLEAR_ON_RESET=1, else IDLE.
- FSM has two states: CLEAR and IDLE.
- CLEAR state:
  - ready=0.
  - Each cycle writes 0 to word[cnt], then cnt increments.
  - After word DEPTH-1 is written, go to IDLE. Clearing takes exactly DEPTH cycles after rst_n rises.
  - req is ignored while in CLEAR.
  - Reset asserted mid-clear restarts clearing from word 0.
- IDLE state: ready=1. A request is accepted on an edge where req&&ready.
- Address decode:
  - Word index = addr[log2(DEPTH)+1:2]; byte offset = addr[1:0].
  - out_of_range when addr >= 4*DEPTH.
  - Misaligned when: size=1 and addr[0]=1; or size=2 and addr[1:0]!=0; or size=3.
- Faulting access (misaligned or out of range):
  - No array write.
  - The matching flag(s) pulse high for one cycle, in the cycle after acceptance. Both flags may pulse together.
  - A faulting load also pulses rvalid with rdata=0.
- Store, no fault: written on the accepting edge.
  - Byte: wdata[7:0] goes to lane addr[1:0].
  - Half: wdata[15:0] goes to lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes.
  - Untouched lanes keep their value.
  - No rvalid pulse.
- Load, no fault:
  - The addressed lane(s) are extracted and sign- or zero-extended to 32 bits.
  - The result is registered into rdata on the accepting edge, so rvalid=1 in the following cycle (latency 1).
- rvalid: high for exactly one cycle per accepted load, else 0.
- rdata: holds its last value until the next load response.
- Back-to-back:
  - One request may be accepted every cycle.
  - A load accepted the cycle after a store to the same word returns the stored data.
  - Only one access per cycle, so there is no same-cycle read/write conflict.
- Address bits above the decoded range are used only for the out_of_range check.

Test Plan:
- Reset, then CLEAR_ON_RESET=1, DEPTH=128:
  - ready stays 0 for 128 cycles after rst_n rises, then goes 1.
  - A word load of addr 0x1FC returns 0x00000000 with rvalid one cycle after acceptance.
- Word store 0x8899AABB to 0x10, then byte load of 0x11:
  - signed (unsigned_ld=0) returns 0xFFFFFFAA;
  - unsigned (unsigned_ld=1) returns 0x000000AA.
- Then half load of 0x12:
  - signed returns 0xFFFF8899;
  - unsigned returns 0x00008899.
- Byte store 0x55 to 0x13, then word load of 0x10 returns 0x5599AABB (other lanes preserved).
- Half store to 0x21:
  - misalign pulses one cycle after acceptance.
  - A word load of 0x20 returns the unchanged value.
  - Word load of 0x22 pulses misalign and rvalid with rdata=0.
- Word load of 0x200 (DEPTH=128): out_of_range and rvalid pulse with rdata=0; array unchanged.
- Reset asserted mid-clear, plus back-to-back traffic:
  - Assert rst_n=0 at clear cycle 50: outputs return to reset values immediately, and clearing restarts at word 0.
  - Then issue a store 0x12345678 to 0x40 followed immediately by a word load of 0x40: the load returns 0x12345678.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with byte/half/word access, sign/zero-extended
// registered loads, fault detection and a post-reset hardware clear sequence.
`timescale 1ns/1ps

module data_memory_ctrl #(
    parameter int DEPTH          = 128,
    parameter int ADDR_W         = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              misalign,
    output logic              out_of_range
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

    state_t state, state_next;

    logic [IDX_W-1:0] cnt;
    logic [3:0][7:0]  mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic             accept;
    logic             fault_mis;
    logic             fault_oor;
    logic             fault;
    logic             clear_we;
    logic             store_we;
    logic [3:0]       be;
    logic [3:0][7:0]  wlanes;
    logic [31:0]      rd_word;
    logic [31:0]      shifted;
    logic [31:0]      ld_val;

    assign idx      = addr[IDX_W+1:2];
    assign off      = addr[1:0];
    assign accept   = req && ready;
    assign clear_we = (state == S_CLEAR);

    assign fault_oor = (addr >= ADDR_W'(4 * DEPTH));
    assign fault_mis = ((size == SZ_HALF) && off[0])
                    || ((size == SZ_WORD) && (off != 2'b00))
                    || (size == 2'd3);
    assign fault     = fault_mis || fault_oor;
    assign store_we  = accept && we && !fault;

    // State register
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RESET_STATE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch forms.
        state_next = state;
        case (state)
            S_CLEAR: if (cnt == IDX_W'(DEPTH - 1)) state_next = S_IDLE;
            S_IDLE:  state_next = S_IDLE;
            default: state_next = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        cnt <= '0;
        else if (clear_we) cnt <= cnt + 1'b1;
    end

    // ready is registered so it is low throughout reset even when clearing is skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready <= 1'b0;
        else        ready <= (state_next == S_IDLE);
    end

    // Store lane enables and lane-replicated write data.
    always_comb begin
        be     = 4'b0000;
        wlanes = wdata;
        case (size)
            SZ_BYTE: begin
                be     = 4'b0001 << off;
                wlanes = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be     = off[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata[15:0]}};
            end
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // NOTE: the array has no reset; it is cleared by the CLEAR sequence instead,
    // which keeps it mappable onto RAM macros.
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[cnt] <= '0;
        end else if (store_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][i] <= wlanes[i];
            end
        end
    end

    assign rd_word = mem[idx];
    assign shifted = rd_word >> {off, 3'b000};

    always_comb begin
        ld_val = rd_word;
        case (size)
            SZ_BYTE: ld_val = {{24{~unsigned_ld & shifted[7]}},  shifted[7:0]};
            SZ_HALF: ld_val = {{16{~unsigned_ld & shifted[15]}}, shifted[15:0]};
            default: ld_val = rd_word;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata        <= '0;
            rvalid       <= 1'b0;
            misalign     <= 1'b0;
            out_of_range <= 1'b0;
        end else begin
            rvalid       <= accept && !we;
            misalign     <= accept && fault_mis;
            out_of_range <= accept && fault_oor;
            if (accept && !we) rdata <= fault ? 32'h0 : ld_val;
        end
    end

endmodule
